// File: rtl/lsu_mem_responder.sv
// Fixed-latency memory responder for the LSU: requests are queued in a FIFO and acked in order.
// Optional macro LSU_MEM_RESPONDER_LDS_BANK_EN gives LDS its own storage bank.
module lsu_mem_responder #(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int ADDR_WORDS_LOG2  = 8,
  parameter int LATENCY          = 4,
  parameter int FIFO_DEPTH_LOG2  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_rd_en,
  input  logic                        mem_wr_en,
  input  logic [31:0]                 mem_addr,
  input  logic [MEMORY_BUS_WIDTH-1:0] mem_wr_data,
  input  logic [6:0]                  mem_tag_req,
  input  logic                        mem_gm_or_lds,
  output logic                        mem_ack,
  output logic [MEMORY_BUS_WIDTH-1:0] mem_rd_data,
  output logic [6:0]                  mem_tag_resp,
  output logic                        busy,
  output logic                        overflow_err
);

  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
`ifdef LSU_MEM_RESPONDER_LDS_BANK_EN
  localparam int BANK_SEL_W = 1;
`else
  localparam int BANK_SEL_W = 0;
`endif
  localparam int STORE_AW    = ADDR_WORDS_LOG2 + BANK_SEL_W;
  localparam int STORE_WORDS = 1 << STORE_AW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0]                 WAIT_LOAD = 4'(LATENCY - 1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE   = (FIFO_DEPTH_LOG2)'(1);
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE   = (FIFO_DEPTH_LOG2+1)'(1);

  logic                        fifo_wr_q   [FIFO_DEPTH];
  logic [ADDR_WORDS_LOG2-1:0]  fifo_addr_q [FIFO_DEPTH];
  logic [MEMORY_BUS_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [6:0]                  fifo_tag_q  [FIFO_DEPTH];
  logic                        fifo_lds_q  [FIFO_DEPTH];
  logic [MEMORY_BUS_WIDTH-1:0] store_q     [STORE_WORDS];

  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
  logic [1:0]                 state_q, state_d;
  logic [3:0]                 wait_cnt_q, wait_cnt_d;
  logic                       overflow_q, overflow_d;

  logic                        req_valid;
  logic [ADDR_WORDS_LOG2-1:0]  req_addr;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        resp_fire;
  logic                        push;
  logic                        drop;
  logic                        head_wr;
  logic [ADDR_WORDS_LOG2-1:0]  head_addr;
  logic [MEMORY_BUS_WIDTH-1:0] head_data;
  logic [6:0]                  head_tag;
  logic                        head_lds;
  logic [STORE_AW-1:0]         head_idx;
  logic                        store_we;
  logic                        unused_bits;

  assign req_valid  = mem_rd_en | mem_wr_en;
  assign req_addr   = mem_addr[ADDR_WORDS_LOG2+1:2];
  assign fifo_full  = count_q[FIFO_DEPTH_LOG2];
  assign fifo_empty = (count_q == '0);
  // Reset masks the response combinationally so nothing is acked or committed in a reset cycle.
  assign resp_fire  = (state_q == ST_RESP) && !rst;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign push       = req_valid && (!fifo_full || resp_fire);
  assign drop       = req_valid && fifo_full && !resp_fire;

  assign head_wr   = fifo_wr_q[rd_ptr_q];
  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];
  assign head_tag  = fifo_tag_q[rd_ptr_q];
  assign head_lds  = fifo_lds_q[rd_ptr_q];

`ifdef LSU_MEM_RESPONDER_LDS_BANK_EN
  assign head_idx    = {head_lds, head_addr};
  assign unused_bits = ^{mem_addr[31:ADDR_WORDS_LOG2+2], mem_addr[1:0]};
`else
  assign head_idx    = head_addr;
  assign unused_bits = ^{mem_addr[31:ADDR_WORDS_LOG2+2], mem_addr[1:0], head_lds};
`endif

  assign store_we     = resp_fire && head_wr;
  assign mem_ack      = resp_fire;
  assign mem_tag_resp = resp_fire ? head_tag : '0;
  assign mem_rd_data  = (resp_fire && !head_wr) ? store_q[head_idx] : '0;
  assign busy         = !fifo_empty || (state_q != ST_IDLE);
  assign overflow_err = overflow_q;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = resp_fire ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d    = count_q;
    if (push && !resp_fire) begin
      count_d = count_q + CNT_ONE;
    end else if (resp_fire && !push) begin
      count_d = count_q - CNT_ONE;
    end
    overflow_d = overflow_q | drop;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty || push) begin
          state_d    = (LATENCY == 1) ? ST_RESP : ST_WAIT;
          wait_cnt_d = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q <= 4'd1) begin
          state_d = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        // Entries left behind the head (or arriving now) start a fresh latency window.
        if ((count_q > CNT_ONE) || push) begin
          state_d    = (LATENCY == 1) ? ST_RESP : ST_WAIT;
          wait_cnt_d = WAIT_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload and storage arrays carry no reset; storage must survive rst.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_wr_q[wr_ptr_q]   <= mem_wr_en;
      fifo_addr_q[wr_ptr_q] <= req_addr;
      fifo_data_q[wr_ptr_q] <= mem_wr_data;
      fifo_tag_q[wr_ptr_q]  <= mem_tag_req;
      fifo_lds_q[wr_ptr_q]  <= mem_gm_or_lds;
    end
    if (store_we) begin
      store_q[head_idx] <= head_data;
    end
  end

endmodule

// File: doc/lsu_mem_responder.md
LSU_MEM_RESPONDER -- requirements
Module: lsu_mem_responder

Interface
REQ-001 SHALL have parameter MEMORY_BUS_WIDTH, default 32, read/write data width.
REQ-002 SHALL have parameter ADDR_WORDS_LOG2, default 8, log2 of words per storage bank.
REQ-003 SHALL have parameter LATENCY, default 4 (legal 1..15), cycles from request to ack.
REQ-004 SHALL have parameter FIFO_DEPTH_LOG2, default 2, log2 of request FIFO entries.
REQ-005 SHALL have port clk  input  1  clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset; rst is synchronous and active-high, and the clock is clk.
REQ-007 SHALL have port mem_rd_en  input  1  read request pulse, one cycle per request.
REQ-008 SHALL have port mem_wr_en  input  1  write request pulse, one cycle per request.
REQ-009 SHALL have port mem_addr  input  32  byte address.
REQ-010 SHALL have port mem_wr_data  input  MEMORY_BUS_WIDTH  write data.
REQ-011 SHALL have port mem_tag_req  input  7  request tag.
REQ-012 SHALL have port mem_gm_or_lds  input  1  space select: 0 = global memory, 1 = LDS.
REQ-013 SHALL have port mem_ack  output  1  one-cycle response pulse.
REQ-014 SHALL have port mem_rd_data  output  MEMORY_BUS_WIDTH  read data, valid while mem_ack is high.
REQ-015 SHALL have port mem_tag_resp  output  7  tag of the acked request, valid while mem_ack is high.
REQ-016 SHALL have port busy  output  1  high while the FIFO is non-empty or the FSM is not IDLE.
REQ-017 SHALL have port overflow_err  output  1  sticky flag: a request was dropped.

Function
REQ-018 SHALL sample a request at every rising edge where mem_rd_en|mem_wr_en=1, and push {rd/wr, word address, data, tag, gm_or_lds} into the FIFO.
REQ-019 SHALL treat mem_rd_en=1 together with mem_wr_en=1 as a write.
REQ-020 SHALL compute word address = mem_addr[ADDR_WORDS_LOG2+1:2]; addr[1:0] and the upper bits are ignored, so out-of-range addresses wrap.
REQ-021 SHALL drop a request that arrives while the FIFO is full, not push it, and set overflow_err=1 until rst.
REQ-022 SHALL, if a pop and a push occur in the same cycle while the FIFO is full, accept the push and raise no error.
REQ-023 SHALL implement FSM states IDLE, WAIT and RESP:
  - IDLE -> WAIT when the FIFO is non-empty, or when a request arrives this cycle (bypass).
  - WAIT counts LATENCY-1 cycles, then goes to RESP.
  - RESP lasts one cycle: it pulses mem_ack, pops the head, then goes to WAIT if more entries remain, else IDLE.
REQ-024 SHALL assert mem_ack exactly LATENCY cycles after the request cycle when the responder was idle; successive acks SHALL be at least LATENCY cycles apart.
REQ-025 SHALL complete requests strictly in FIFO order; mem_tag_resp equals the head entry's tag.
REQ-026 SHALL commit a write to storage at the rising edge ending its RESP cycle, and drive mem_rd_data=0 for write acks.
REQ-027 SHALL drive mem_rd_data for a read from storage in its RESP cycle, so a read after a write to the same address returns the new data.
REQ-028 SHALL hold mem_rd_data and mem_tag_resp at 0 whenever mem_ack=0.

Reset
REQ-029 SHALL, on rst, set mem_ack=0, mem_rd_data=0, mem_tag_resp=0, busy=0, overflow_err=0, FSM=IDLE and FIFO empty.
REQ-030 SHALL discard in-flight and queued requests on rst mid-operation, with no ack afterwards; requests sampled during rst are ignored.
REQ-031 SHALL NOT clear storage contents on rst.

Configuration
REQ-032 SHALL, with macro LSU_MEM_RESPONDER_LDS_BANK_EN defined, use separate 2^ADDR_WORDS_LOG2-word global and LDS banks selected by the stored gm_or_lds.
REQ-033 SHALL, without LSU_MEM_RESPONDER_LDS_BANK_EN, use one shared bank and ignore gm_or_lds.

Verification
REQ-034 SHALL cover: write addr 0x10 data 0xDEADBEEF tag 5, then read addr 0x10 tag 6 -> acks 4 cycles after each request, read ack returns 0xDEADBEEF with tag 6.
REQ-035 SHALL cover: 4 back-to-back reads, tags 1..4 -> acks in order 1,2,3,4, spaced exactly 4 cycles apart, busy low after the last ack.
REQ-036 SHALL cover: 6 back-to-back requests with the FIFO full -> exactly one dropped (bypass + 4 queued accepted, per REQ-023), overflow_err=1 and sticky.
REQ-037 SHALL cover: write 0x11111111 to addr 0x400 (ADDR_WORDS_LOG2=8), then read addr 0x0 -> 0x11111111 (wrap).
REQ-038 SHALL cover: with LDS_BANK_EN, write 0xA to global addr 0 and 0xB to LDS addr 0 -> reads return 0xA and 0xB; without the macro both return 0xB.
REQ-039 SHALL cover: rst pulsed 2 cycles after a read request -> no mem_ack ever, busy=0, overflow_err=0.
